// File: rtl/pc_predict_unit.sv
// Fetch PC register with a direct-mapped BTB (2-bit saturating counters),
// branch/jump recovery, flush generation and saturating performance counters.
module pc_predict_unit #(
    parameter int unsigned    PC_W      = 32,
    parameter int unsigned    BTB_DEPTH = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned    CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_pred_taken,
    input  logic [PC_W-1:0]   upd_pred_target,
    output logic [PC_W-1:0]   pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    output logic              flush,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  mispredict_count
);

    localparam int unsigned IDX_W = $clog2(BTB_DEPTH);
    localparam int unsigned TAG_W = PC_W - IDX_W;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

    logic [BTB_DEPTH-1:0] valid_q;
    logic [1:0]           ctr_q [BTB_DEPTH];
    logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
    logic [PC_W-1:0]      tgt_q [BTB_DEPTH];

    logic [IDX_W-1:0] look_idx;
    logic [TAG_W-1:0] look_tag;
    logic             look_hit;
    logic [PC_W-1:0]  pc_plus1;
    logic             pred_taken_w;
    logic [PC_W-1:0]  pred_target_w;

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             mp;
    logic [PC_W-1:0]  recover_pc;
    logic             ctr_we;
    logic [1:0]       ctr_wdata;
    logic             tgt_we;
    logic             alloc;

    // Lookup for the current fetch PC; reads old contents during an update
    always_comb begin
        look_idx      = pc_q[IDX_W-1:0];
        look_tag      = pc_q[PC_W-1:IDX_W];
        look_hit      = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
        pc_plus1      = pc_q + PC_W'(1);
        pred_taken_w  = look_hit && ctr_q[look_idx][1];
        pred_target_w = look_hit ? tgt_q[look_idx] : pc_plus1;
    end

    // Resolution: mispredict detection and recovery target
    always_comb begin
        mp = upd_valid && ((upd_taken != upd_pred_taken) ||
                           (upd_taken && (upd_target != upd_pred_target)));
        recover_pc = upd_taken ? upd_target : (upd_pc + PC_W'(1));
    end

    // BTB write controls: train on hit, allocate on taken miss
    always_comb begin
        upd_idx   = upd_pc[IDX_W-1:0];
        upd_tag   = upd_pc[PC_W-1:IDX_W];
        upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        alloc     = upd_valid && !upd_hit && upd_taken;
        ctr_we    = upd_valid && (upd_hit || upd_taken);
        tgt_we    = upd_valid && upd_taken;
        ctr_wdata = ctr_q[upd_idx];
        if (!upd_hit) begin
            ctr_wdata = 2'b10;
        end else if (upd_taken) begin
            if (ctr_q[upd_idx] != 2'b11) ctr_wdata = ctr_q[upd_idx] + 2'(1);
        end else begin
            if (ctr_q[upd_idx] != 2'b00) ctr_wdata = ctr_q[upd_idx] - 2'(1);
        end
    end

    // Next fetch PC: older mispredict beats jump, both beat stall
    always_comb begin
        pc_d = pc_plus1;
        if (mp) begin
            pc_d = recover_pc;
        end else if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pred_taken_w) begin
            pc_d = pred_target_w;
        end
    end

    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (upd_valid && (br_cnt_q != {CNT_W{1'b1}})) br_cnt_d = br_cnt_q + CNT_W'(1);
        if (mp && (mp_cnt_q != {CNT_W{1'b1}}))        mp_cnt_d = mp_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
            valid_q  <= '0;
            ctr_q    <= '{default: 2'b01};
        end else begin
            pc_q     <= pc_d;
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
            if (alloc)  valid_q[upd_idx] <= 1'b1;
            if (ctr_we) ctr_q[upd_idx]   <= ctr_wdata;
        end
    end

    // Tags and targets are qualified by valid, so they carry no reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (alloc)  tag_q[upd_idx] <= upd_tag;
            if (tgt_we) tgt_q[upd_idx] <= upd_target;
        end
    end

    assign pc               = pc_q;
    assign pred_taken       = pred_taken_w;
    assign pred_target      = pred_target_w;
    assign flush            = mp || redirect_valid;
    assign branch_count     = br_cnt_q;
    assign mispredict_count = mp_cnt_q;

endmodule

// File: doc/pc_predict_unit.md
Name: pc_predict_unit

Overview:
- Parametrised successor to the combinational next-PC selector. Owns the fetch PC register and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Predicts the next fetch PC and applies branch resolutions from the decode stage. On a misprediction or jump it redirects fetch and raises flush.
- Counts resolved branches and mispredictions for performance monitoring.
- PCs are word addresses: sequential successor is pc + 1.

Parameters:
PC_W, 32, PC width in bits
BTB_DEPTH, 16, number of BTB entries; power of two >= 2; IDX_W = log2(BTB_DEPTH)
RESET_PC, 0, PC value loaded on reset
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  hold pc (fetch/decode stall)
redirect_valid  in  1  unconditional jump (j/jal/jr) resolved in decode
redirect_pc  in  PC_W  jump target
upd_valid  in  1  conditional branch (beq/bne) resolved this cycle
upd_pc  in  PC_W  PC of the resolved branch
upd_taken  in  1  actual outcome
upd_target  in  PC_W  actual taken target (upd_pc + offset + 1)
upd_pred_taken  in  1  prediction carried down the pipe for this branch
upd_pred_target  in  PC_W  predicted target carried down the pipe
pc  out  PC_W  current fetch PC (registered)
pred_taken  out  1  prediction for pc (combinational from BTB)
pred_target  out  PC_W  predicted target for pc
flush  out  1  squash younger instructions this cycle (combinational)
branch_count  out  CNT_W  resolved branches, saturating
mispredict_count  out  CNT_W  mispredictions, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset (rst) is synchronous and active-high. Reset dominates all other inputs.
- Reset values:
  - pc = RESET_PC.
  - All BTB valid bits = 0; counters = 2'b01; tags and targets don't-care.
  - branch_count = mispredict_count = 0.
  - Consequence: pred_taken = 0 and flush = 0 on the first cycle after reset, provided redirect_valid and upd_valid are low.
- Lookup (combinational):
  - idx = pc[IDX_W-1:0]; tag = pc[PC_W-1:IDX_W].
  - hit = valid[idx] && tag_mem[idx] == tag.
  - pred_taken = hit && ctr[idx][1].
  - pred_target = target[idx] when hit, else pc + 1.
- Mispredict (mp): upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
- Recovery PC: upd_taken ? upd_target : upd_pc + 1.
- flush = mp || redirect_valid.
- Next-PC priority, registered on clk, highest first:
  1. rst: RESET_PC.
  2. mp: recovery PC.
  3. redirect_valid: redirect_pc.
  4. stall: pc unchanged.
  5. pred_taken: pred_target.
  6. otherwise: pc + 1.
  - mp and redirect override stall.
  - mp and redirect_valid together: mp wins (older instruction).
- All PC arithmetic is modulo 2^PC_W; pc + 1 wraps from all-ones to 0.
- BTB update, on upd_valid, independent of stall/redirect; u = upd_pc[IDX_W-1:0]:
  - Hit at u:
    - ctr saturating: +1 if taken (max 3), -1 if not (min 0).
    - If taken, target[u] = upd_target.
  - Miss and taken: allocate, overwriting any entry. valid = 1, tag written, target = upd_target, ctr = 2'b10.
  - Miss and not taken: no change.
- Read-during-write: a lookup at the entry being updated in the same cycle sees old contents. The new contents are visible the next cycle. There is no bypass.
- Counters:
  - branch_count += 1 on each upd_valid.
  - mispredict_count += 1 on each mp.
  - Both saturate at all-ones; no wrap.
- Single-cycle latency: an update or redirect in cycle N affects pc in cycle N+1.

Test Plan:
- Reset then 4 idle cycles, RESET_PC=0x100, BTB empty -> pc sequence 0x100, 0x101, 0x102, 0x103, 0x104; pred_taken=0; flush=0.
- Branch at 0x104 resolved taken to 0x120, upd_pred_taken=0 -> flush=1 that cycle; next pc=0x120; entry 4 valid, ctr=2; mispredict_count=1. Fetch 0x104 again -> pred_taken=1, pred_target=0x120, next pc=0x120.
- Same branch resolved not-taken 3 times -> ctr 2→1→0→0, no underflow. The first resolution mispredicts (pred 1) and recovers to 0x105.
- stall=1 with redirect_valid=1, redirect_pc=0x200 -> pc=0x200 next cycle, flush=1. stall=1 alone -> pc holds for 3 cycles.
- Same cycle: upd mispredict to 0x300 and redirect_valid to 0x400 -> pc=0x300. Aliasing branch 0x114 (idx 4, different tag) taken to 0x150 -> replaces entry, tag updated; fetch 0x104 now misses.
- PC_W=8, pc=0xFF, no prediction -> next pc=0x00. CNT_W=2 with 5 mispredicts -> mispredict_count holds at 3.
